// File: rtl/posit_round_pipe.sv
// Multi-lane posit rounding stage: derives round/sticky per lane and applies RNE/RTZ(/stochastic) with posit saturation.
// Latency 2 cycles accept->out_valid (S1 round/sticky register, S2 rounded-body register); 1 beat/cycle sustained.
// Backpressure: valid/ready; each stage holds while the next is full and not draining; in_ready = !s1 | !s2 | out_ready.
//
// Ports: clk/rst (async, active-high); in_valid/in_ready/in_mode plus per-lane packed fields
// in_body, in_frac_full, in_frac_len, in_frac_diff, in_k, in_exp, in_frac_trunc (lane l at [l*W +: W]);
// out_valid/out_ready, out_body (rounded body per lane), out_inexact (round|sticky per lane).
// Optional feature macro: STOCHASTIC_ROUND_EN (adds a 16-bit LFSR; mode 2 becomes stochastic rounding).
module posit_round_pipe #(
    parameter int N      = 16,
    parameter int ES     = 1,
    parameter int FRAC_W = 44,
    parameter int LANES  = 1,
    localparam int K_W   = $clog2(N) + 1,
    localparam int D_W   = $clog2(FRAC_W) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_mode,
    input  logic [LANES*(N-1)-1:0]   in_body,
    input  logic [LANES*FRAC_W-1:0]  in_frac_full,
    input  logic [LANES*K_W-1:0]     in_frac_len,
    input  logic [LANES*D_W-1:0]     in_frac_diff,
    input  logic [LANES*K_W-1:0]     in_k,
    input  logic [LANES*ES-1:0]      in_exp,
    input  logic [LANES-1:0]         in_frac_trunc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*(N-1)-1:0]   out_body,
    output logic [LANES-1:0]         out_inexact
);

    localparam int B_W = N - 1;
    // Regime extremes: largest k still carrying exponent bits, and the most negative regime.
    localparam logic signed [K_W-1:0] K_MAX = K_W'(N - 2 - ES);
    localparam logic signed [K_W-1:0] K_MIN = K_W'(2 - N);

    // Returns {round, sticky} for one lane.
    function automatic logic [1:0] round_sticky(
        input logic        [FRAC_W-1:0] frac,
        input logic        [D_W-1:0]    diff,
        input logic signed [K_W-1:0]    flen,
        input logic signed [K_W-1:0]    k,
        input logic        [ES-1:0]     ex,
        input logic                     trunc
    );
        logic rnd;
        logic stk;
        rnd = 1'b0;
        stk = trunc;
        if (flen < 0) begin
            // No fraction bits fit: rounding is decided by the regime/exponent alone.
            stk = 1'b0;
            if (k == K_MAX)
                rnd = (ex != '0) && (frac != '0);
            else if (k == K_MIN)
                rnd = (ex != '0);
        end else if (diff != '0) begin
            for (int i = 0; i < FRAC_W; i++) begin
                if (i == int'(diff) - 1)
                    rnd = frac[i];
                else if (i < int'(diff) - 1)
                    stk = stk | frac[i];
            end
        end
        return {rnd, stk};
    endfunction

    // Increment with saturation: all-ones (maxpos) never wraps, zero is forced to minpos.
    function automatic logic [B_W-1:0] sat_round(input logic [B_W-1:0] b, input logic up);
        if (b == '1)
            return b;
        else if (b == '0)
            return B_W'(1);
        else
            return b + B_W'(up);
    endfunction

    logic                  s1_valid;
    logic                  s2_valid;
    logic                  s1_en;
    logic                  s2_en;
    logic [LANES*B_W-1:0]  s1_body;
    logic [LANES-1:0]      s1_round;
    logic [LANES-1:0]      s1_sticky;
    logic [1:0]            s1_mode;
    logic [LANES-1:0]      rnd_d;
    logic [LANES-1:0]      stk_d;
    logic [LANES-1:0]      up;
    logic [LANES*B_W-1:0]  body_d;

    assign s2_en     = !s2_valid || out_ready;
    assign s1_en     = !s1_valid || s2_en;
    assign in_ready  = s1_en;
    assign out_valid = s2_valid;

`ifdef STOCHASTIC_ROUND_EN
    logic [15:0]          lfsr;
    logic [2*LANES-1:0]   s1_rnd;

    // Fibonacci LFSR x^16+x^14+x^13+x^11, stepped once per accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr   <= 16'hACE1;
            s1_rnd <= '0;
        end else if (in_valid && s1_en) begin
            lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            s1_rnd <= lfsr[2*LANES-1:0];
        end
    end
`endif

    always_comb begin
        rnd_d = '0;
        stk_d = '0;
        for (int l = 0; l < LANES; l++) begin
            {rnd_d[l], stk_d[l]} = round_sticky(in_frac_full[l*FRAC_W +: FRAC_W],
                                                in_frac_diff[l*D_W +: D_W],
                                                in_frac_len[l*K_W +: K_W],
                                                in_k[l*K_W +: K_W],
                                                in_exp[l*ES +: ES],
                                                in_frac_trunc[l]);
        end
    end

    always_comb begin
        up     = '0;
        body_d = '0;
        for (int l = 0; l < LANES; l++) begin
            case (s1_mode)
                2'd1: up[l] = 1'b0;
`ifdef STOCHASTIC_ROUND_EN
                2'd2: up[l] = s1_round[l] ? (s1_sticky[l] | s1_rnd[2*l])
                                          : (s1_sticky[l] & s1_rnd[2*l+1] & s1_rnd[2*l]);
`endif
                // RNE; reserved mode 3 (and mode 2 without the LFSR) fall here.
                default: up[l] = s1_round[l] & (s1_sticky[l] | s1_body[l*B_W]);
            endcase
            body_d[l*B_W +: B_W] = sat_round(s1_body[l*B_W +: B_W], up[l]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            s1_body     <= '0;
            s1_round    <= '0;
            s1_sticky   <= '0;
            s1_mode     <= 2'd0;
            out_body    <= '0;
            out_inexact <= '0;
        end else begin
            if (s1_en) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_body   <= in_body;
                    s1_round  <= rnd_d;
                    s1_sticky <= stk_d;
                    s1_mode   <= in_mode;
                end
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_body    <= body_d;
                    out_inexact <= s1_round | s1_sticky;
                end
            end
        end
    end

endmodule
